sc_dmem_io: RTL and testbench
=============================

SC_DMEM_IO -- requirements
Module: sc_dmem_io

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port clrn, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port addr, input, 32 bits: byte address from the CPU ALU output.
REQ-004 SHALL have port wdata, input, 32 bits: store data from the CPU.
REQ-005 SHALL have port wmem, input, 1 bit: store strobe, sampled at clk rise.
REQ-006 SHALL have port rdata, output, 32 bits: load data to the CPU, combinational from addr.
REQ-007 SHALL have port out_data, output, 8 bits: FIFO head byte.
REQ-008 SHALL have port out_valid, output, 1 bit: FIFO non-empty.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts head.
REQ-010 SHALL have port timer_irq, output, 1 bit: timer match flag.

Function
REQ-011 SHALL decode RAM when addr[31:10]==0: 256x32 words, index addr[9:2], addr[1:0] ignored.
REQ-012 SHALL return RAM[index] on rdata combinationally and write wdata on clk rise when wmem=1; read-during-write returns old word.
REQ-013 SHALL decode IO when addr[31:4]==28'h0000800, register = addr[3:2]: 0 DATA, 1 STATUS, 2 TIMER_CNT, 3 TIMER_CMP.
REQ-014 SHALL return rdata=0 and ignore stores for any address outside RAM and IO.
REQ-015 SHALL push wdata[7:0] into a 4-entry 8-bit FIFO on a store to DATA; DATA reads return 0.
REQ-016 SHALL drive STATUS read as {25'b0, overflow, timer_flag, count[2:0], full, empty}; count 0..4.
REQ-017 SHALL pop the head at clk rise when out_valid=1 and out_ready=1; out_data=0 when empty.
REQ-018 SHALL accept a push while full only if a pop occurs in the same cycle; otherwise drop the byte and set sticky overflow.
REQ-019 SHALL, on simultaneous push and pop, keep count unchanged; push to empty FIFO is visible on out_valid the next cycle.
REQ-020 SHALL wrap read/write pointers modulo 4.
REQ-021 SHALL clear overflow on a store to STATUS with wdata[6]=1 and timer_flag with wdata[5]=1; a set event in the same cycle wins over clear.
REQ-022 SHALL increment TIMER_CNT every cycle; when CNT==CMP, next edge loads CNT=0 and sets timer_flag.
REQ-023 SHALL give a store to TIMER_CNT priority over increment and match reload; stores to TIMER_CMP take effect the next cycle.
REQ-024 SHALL drive timer_irq = timer_flag.

Reset
REQ-025 SHALL, while clrn=0, force FIFO empty (pointers, count 0), out_valid=0, out_data=0, overflow=0, TIMER_CNT=0, TIMER_CMP=32'hFFFF_FFFF, timer_flag=0, timer_irq=0.
REQ-026 SHALL not reset RAM contents; reset mid-operation discards FIFO contents and any pending store.

Configuration
REQ-027 SHALL compile the timer only when macro SC_DMEM_IO_TIMER_EN is defined.
REQ-028 SHALL, without SC_DMEM_IO_TIMER_EN, read TIMER_CNT/TIMER_CMP as 0, ignore their stores, hold STATUS bit5=0 and timer_irq=0; RAM and FIFO unchanged.

Verification
REQ-029 SHALL cover: store 32'hDEADBEEF to 0x0000_0010, then load 0x0000_0013 -> rdata=32'hDEADBEEF; load 0x0000_0400 -> 0.
REQ-030 SHALL cover: out_ready=0, store 0x11,0x22,0x33,0x44,0x55 to 0x8000 -> STATUS=32'h0000_0052 (overflow, count 4, full); out_ready=1 -> out_data 0x11,0x22,0x33,0x44 on consecutive cycles, then out_valid=0.
REQ-031 SHALL cover: FIFO full, store 0x66 with out_ready=1 same cycle -> count stays 4, no overflow, 0x66 delivered last.
REQ-032 SHALL cover: store CMP=3, CNT=0 -> timer_irq rises 4 cycles after CNT store, CNT reads 0 then; store STATUS 0x20 -> irq clears next cycle.
REQ-033 SHALL cover: clrn pulsed low asynchronously with 2 bytes queued and irq set -> out_valid=0, timer_irq=0, STATUS=32'h0000_0001 immediately, RAM word 0x10 still 32'hDEADBEEF.
REQ-034 SHALL cover: build without SC_DMEM_IO_TIMER_EN, store 5 to 0x8008 -> read 0x8008=0, timer_irq stays 0.

Source files
------------

// File: rtl/sc_dmem_io.sv
// Data memory for a single-cycle CPU: 256x32 RAM plus a memory-mapped byte FIFO
// and an optional timer that is built only when SC_DMEM_IO_TIMER_EN is defined.
module sc_dmem_io (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wmem,
  output logic [31:0] rdata,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        timer_irq
);

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CNT    = 2'd2;
  localparam logic [1:0] REG_CMP    = 2'd3;

  logic       ram_sel;
  logic       io_sel;
  logic [7:0] ram_idx;
  logic [1:0] io_reg;
  logic       unused_addr;

  assign ram_sel     = (addr[31:10] == 22'd0);
  assign io_sel      = (addr[31:4] == 28'h0000800);
  assign ram_idx     = addr[9:2];
  assign io_reg      = addr[3:2];
  assign unused_addr = &{1'b0, addr[1:0]};

  logic st_data;
  logic st_status;

  assign st_data   = wmem & io_sel & (io_reg == REG_DATA);
  assign st_status = wmem & io_sel & (io_reg == REG_STATUS);

  // live is low during reset and for the first edge after release, so a store
  // presented while reset is asserted never reaches the RAM.
  logic live;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) live <= 1'b0;
    else       live <= 1'b1;
  end

  logic [31:0] ram [256];

  always_ff @(posedge clk) begin
    if (wmem && ram_sel && live) ram[ram_idx] <= wdata;
  end

  logic [7:0] fifo_mem [4];
  logic [1:0] wptr;
  logic [1:0] rptr;
  logic [2:0] count;
  logic       overflow;
  logic       timer_flag;
  logic       full;
  logic       empty;
  logic       pop;
  logic       push_ok;

  assign empty   = (count == 3'd0);
  assign full    = (count == 3'd4);
  assign pop     = out_valid & out_ready;
  assign push_ok = st_data & (~full | pop);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wptr     <= 2'd0;
      rptr     <= 2'd0;
      count    <= 3'd0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 2'd1;
      if (pop)     rptr <= rptr + 2'd1;
      case ({push_ok, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      // a dropped byte in the same cycle outranks a software clear
      if (st_data && full && !pop)    overflow <= 1'b1;
      else if (st_status && wdata[6]) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wptr] <= wdata[7:0];
  end

  assign out_valid = ~empty;
  assign out_data  = empty ? 8'd0 : fifo_mem[rptr];

  logic [31:0] timer_cnt;
  logic [31:0] timer_cmp;

`ifdef SC_DMEM_IO_TIMER_EN
  logic st_cnt;
  logic st_cmp;
  logic match;

  assign st_cnt = wmem & io_sel & (io_reg == REG_CNT);
  assign st_cmp = wmem & io_sel & (io_reg == REG_CMP);
  assign match  = (timer_cnt == timer_cmp);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      timer_cnt  <= 32'd0;
      timer_cmp  <= 32'hFFFF_FFFF;
      timer_flag <= 1'b0;
    end else begin
      if (st_cnt)     timer_cnt <= wdata;
      else if (match) timer_cnt <= 32'd0;
      else            timer_cnt <= timer_cnt + 32'd1;
      if (st_cmp) timer_cmp <= wdata;
      if (match)                      timer_flag <= 1'b1;
      else if (st_status && wdata[5]) timer_flag <= 1'b0;
    end
  end
`else
  assign timer_cnt  = 32'd0;
  assign timer_cmp  = 32'd0;
  assign timer_flag = 1'b0;
`endif

  assign timer_irq = timer_flag;

  logic [31:0] io_rdata;

  always_comb begin
    io_rdata = 32'd0;
    case (io_reg)
      REG_STATUS: io_rdata = {25'd0, overflow, timer_flag, count, full, empty};
      REG_CNT:    io_rdata = timer_cnt;
      REG_CMP:    io_rdata = timer_cmp;
      default:    io_rdata = 32'd0;
    endcase
    if (ram_sel)     rdata = ram[ram_idx];
    else if (io_sel) rdata = io_rdata;
    else             rdata = 32'd0;
  end

endmodule

// File: tb/tb_sc_dmem_io.sv
// Directed bench for sc_dmem_io: RAM decode, FIFO scoreboard, timer (or its
// absence when SC_DMEM_IO_TIMER_EN is undefined) and asynchronous reset.
module tb_sc_dmem_io;

  logic        clk = 1'b0;
  logic        clrn;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wmem;
  logic [31:0] rdata;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        timer_irq;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] sb [$];

`ifdef SC_DMEM_IO_TIMER_EN
  localparam bit TIMER_ON = 1'b1;
`else
  localparam bit TIMER_ON = 1'b0;
`endif

  sc_dmem_io dut (
    .clk       (clk),
    .clrn      (clrn),
    .addr      (addr),
    .wdata     (wdata),
    .wmem      (wmem),
    .rdata     (rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wmem  = 1'b1;
    tick();
    wmem  = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  task automatic push_byte(input logic [7:0] b);
    store(32'h0000_8000, {24'd0, b});
  endtask

  // Pops every queued byte on consecutive cycles, then expects an empty FIFO.
  task automatic drain(input string tag);
    out_ready = 1'b1;
    while (sb.size() > 0) begin
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_data"}, {24'd0, out_data}, {24'd0, sb.pop_front()});
      tick();
    end
    out_ready = 1'b0;
    check({tag, "_empty_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_empty_data"}, {24'd0, out_data}, 32'd0);
  endtask

  initial begin
    clrn      = 1'b0;
    addr      = 32'h0000_8004;
    wdata     = 32'd0;
    wmem      = 1'b0;
    out_ready = 1'b0;
    #3;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_irq", {31'd0, timer_irq}, 32'd0);
    check("rst_status", rdata, 32'h0000_0001);
    #20;
    clrn = 1'b1;
    tick();
    rd_check("rst_cmp", 32'h0000_800C, TIMER_ON ? 32'hFFFF_FFFF : 32'd0);

    // RAM decode, byte offset ignored, out-of-range alias rejected
    store(32'h0000_0010, 32'hDEAD_BEEF);
    rd_check("ram_rd_0x13", 32'h0000_0013, 32'hDEAD_BEEF);
    rd_check("ram_rd_0x400", 32'h0000_0400, 32'd0);
    store(32'h0000_0000, 32'd0);
    store(32'h0000_0400, 32'h1234_5678);
    rd_check("ram_no_alias", 32'h0000_0000, 32'd0);
    rd_check("data_reg_rd", 32'h0000_8000, 32'd0);
    rd_check("unmapped_rd", 32'h0000_8010, 32'd0);

    store(32'h0000_0014, 32'hAAAA_5555);
    addr  = 32'h0000_0014;
    wdata = 32'h0F0F_F0F0;
    wmem  = 1'b1;
    #1;
    check("rdw_old_word", rdata, 32'hAAAA_5555);
    tick();
    wmem = 1'b0;
    #1;
    check("rdw_new_word", rdata, 32'h0F0F_F0F0);

    // fill past capacity with consumer stalled
    push_byte(8'h11); sb.push_back(8'h11);
    push_byte(8'h22); sb.push_back(8'h22);
    push_byte(8'h33); sb.push_back(8'h33);
    push_byte(8'h44); sb.push_back(8'h44);
    push_byte(8'h55);
    rd_check("ovf_status", 32'h0000_8004, 32'h0000_0052);
    drain("drain1");
    rd_check("status_after_drain", 32'h0000_8004, 32'h0000_0041);
    store(32'h0000_8004, 32'h0000_0040);
    rd_check("ovf_cleared", 32'h0000_8004, 32'h0000_0001);

    // push while full with a simultaneous pop
    push_byte(8'hA1); sb.push_back(8'hA1);
    push_byte(8'hA2); sb.push_back(8'hA2);
    push_byte(8'hA3); sb.push_back(8'hA3);
    push_byte(8'hA4); sb.push_back(8'hA4);
    rd_check("full_status", 32'h0000_8004, 32'h0000_0012);
    addr      = 32'h0000_8000;
    wdata     = 32'h0000_0066;
    wmem      = 1'b1;
    out_ready = 1'b1;
    check("pp_head", {24'd0, out_data}, {24'd0, sb.pop_front()});
    sb.push_back(8'h66);
    tick();
    wmem      = 1'b0;
    out_ready = 1'b0;
    rd_check("pp_status", 32'h0000_8004, 32'h0000_0012);
    drain("drain2");
    rd_check("pp_final_status", 32'h0000_8004, 32'h0000_0001);

`ifdef SC_DMEM_IO_TIMER_EN
    store(32'h0000_800C, 32'd3);
    store(32'h0000_8008, 32'd0);
    rd_check("tmr_cnt0", 32'h0000_8008, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("tmr_irq_low", {31'd0, timer_irq}, 32'd0);
      rd_check("tmr_cnt", 32'h0000_8008, i);
    end
    tick();
    check("tmr_irq_rise", {31'd0, timer_irq}, 32'd1);
    rd_check("tmr_cnt_reload", 32'h0000_8008, 32'd0);
    rd_check("tmr_status", 32'h0000_8004, 32'h0000_0021);
    store(32'h0000_8004, 32'h0000_0020);
    check("tmr_irq_clear", {31'd0, timer_irq}, 32'd0);
    for (int i = 0; i < 10 && !timer_irq; i++) tick();
    check("tmr_irq_rearm", {31'd0, timer_irq}, 32'd1);
`else
    store(32'h0000_8008, 32'd5);
    rd_check("notmr_cnt", 32'h0000_8008, 32'd0);
    store(32'h0000_800C, 32'd2);
    rd_check("notmr_cmp", 32'h0000_800C, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("notmr_irq", {31'd0, timer_irq}, 32'd0);
    end
    rd_check("notmr_status", 32'h0000_8004, 32'h0000_0001);
`endif

    // asynchronous reset with bytes queued
    push_byte(8'hB1);
    push_byte(8'hB2);
    rd_check("pre_rst_status", 32'h0000_8004, TIMER_ON ? 32'h0000_0028 : 32'h0000_0008);
    #2;
    clrn = 1'b0;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_data", {24'd0, out_data}, 32'd0);
    check("arst_irq", {31'd0, timer_irq}, 32'd0);
    check("arst_status", rdata, 32'h0000_0001);
    rd_check("arst_ram", 32'h0000_0010, 32'hDEAD_BEEF);
    wdata = 32'd0;
    wmem  = 1'b1;
    tick();
    wmem = 1'b0;
    check("arst_store_dropped", rdata, 32'hDEAD_BEEF);
    #3;
    clrn = 1'b1;
    tick();
    rd_check("post_rst_cmp", 32'h0000_800C, TIMER_ON ? 32'hFFFF_FFFF : 32'd0);
    push_byte(8'h77); sb.push_back(8'h77);
    drain("drain3");
    rd_check("post_rst_status", 32'h0000_8004, 32'h0000_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
